// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation command sequencer.
// State codes are fixed because the controller reads them back on `state`.
package irrig_pkg;

  localparam int LVL_W = 3;
  localparam int CNT_W = 8;

  localparam int DEF_DEB_TICKS = 3;
  localparam int DEF_ASP_TICKS = 20;
  localparam int DEF_GOT_TICKS = 40;
  localparam int DEF_ADB_TICKS = 5;
  localparam int DEF_MIN_LEVEL = 2;
  localparam int DEF_WAIT_MAX  = 100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_RUN_ASP = 3'd2,
    ST_RUN_GOT = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

endpackage

// File: rtl/irrig_cmd_sequencer_btn_debounce.sv
// Panel switch conditioning: 2-flop synchronizer, tick-based debounce,
// and a one-tick press pulse on the rising edge of the debounced level.
module btn_debounce
  import irrig_pkg::*;
#(
  parameter int DEB_TICKS = DEF_DEB_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_press
);

  logic [1:0]       r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_done;

  assign w_diff = r_sync[1] ^ r_level;
  assign w_done = w_diff && (r_cnt == CNT_W'(DEB_TICKS - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (i_tick) begin
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (w_done) begin
          r_cnt   <= '0;
          r_level <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Press fires on the same tick the new level is accepted.
  assign o_press = i_tick & w_done & r_sync[1];

endmodule

// File: rtl/irrig_cmd_sequencer.sv
// Operator-side command sequencer: queues panel requests and drives
// timed asp/got/adb levels, gated by tank level and inlet valve.
module irrig_cmd_sequencer
  import irrig_pkg::*;
#(
  parameter int DEB_TICKS = DEF_DEB_TICKS,
  parameter int ASP_TICKS = DEF_ASP_TICKS,
  parameter int GOT_TICKS = DEF_GOT_TICKS,
  parameter int ADB_TICKS = DEF_ADB_TICKS,
  parameter int MIN_LEVEL = DEF_MIN_LEVEL,
  parameter int WAIT_MAX  = DEF_WAIT_MAX
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             btn_asp,
  input  logic             btn_got,
  input  logic             btn_adb,
  input  logic [LVL_W-1:0] nivel,
  input  logic             ve,
  output logic             asp,
  output logic             got,
  output logic             adb,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] ASP_CNT  = CNT_W'(ASP_TICKS);
  localparam logic [CNT_W-1:0] GOT_CNT  = CNT_W'(GOT_TICKS);
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] ADB_THR  = CNT_W'(ASP_TICKS - ADB_TICKS);
  localparam logic [LVL_W-1:0] MIN_LVL  = LVL_W'(MIN_LEVEL);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_wcnt;
  logic             r_req_asp;
  logic             r_req_got;
  logic             r_adb_armed;
  logic             r_adb_use;
  logic             r_asp;
  logic             r_got;
  logic             r_adb;
  logic             r_busy;
  logic             r_fault;

  logic             w_press_asp;
  logic             w_press_got;
  logic             w_press_adb;
  logic             w_any_press;
  logic             w_level_ok;
  logic             w_run;
  logic             w_to_fault;
  logic [CNT_W-1:0] w_cnt_dec;

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_asp (
    .clock   (clock),
    .reset   (reset),
    .i_tick  (tick),
    .i_raw   (btn_asp),
    .o_press (w_press_asp)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_got (
    .clock   (clock),
    .reset   (reset),
    .i_tick  (tick),
    .i_raw   (btn_got),
    .o_press (w_press_got)
  );

  btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_adb (
    .clock   (clock),
    .reset   (reset),
    .i_tick  (tick),
    .i_raw   (btn_adb),
    .o_press (w_press_adb)
  );

  assign w_any_press = w_press_asp | w_press_got | w_press_adb;
  assign w_level_ok  = (nivel >= MIN_LVL) && !ve;
  assign w_run       = (r_state == ST_RUN_ASP) || (r_state == ST_RUN_GOT);
  assign w_cnt_dec   = r_cnt - CNT_W'(1);

  // Empty tank beats normal completion; wait timeout expires on the last count.
  assign w_to_fault = (w_run && (nivel == '0))
                   || ((r_state == ST_WAIT) && !w_level_ok
                       && (r_wcnt == CNT_W'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_req_asp   <= 1'b0;
      r_req_got   <= 1'b0;
      r_adb_armed <= 1'b0;
      r_adb_use   <= 1'b0;
      r_asp       <= 1'b0;
      r_got       <= 1'b0;
      r_adb       <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
    end else if (tick) begin
      r_req_asp   <= r_req_asp | w_press_asp;
      r_req_got   <= r_req_got | w_press_got;
      r_adb_armed <= r_adb_armed | w_press_adb;
      unique case (r_state)
        ST_IDLE: begin
          if (r_req_asp && w_level_ok) begin
            r_state     <= ST_RUN_ASP;
            r_cnt       <= ASP_CNT;
            r_req_asp   <= w_press_asp;
            r_adb_use   <= r_adb_armed;
            r_adb_armed <= w_press_adb;
            r_asp       <= 1'b1;
            r_adb       <= r_adb_armed;
            r_busy      <= 1'b1;
          end else if (r_req_got && w_level_ok) begin
            r_state   <= ST_RUN_GOT;
            r_cnt     <= GOT_CNT;
            r_req_got <= w_press_got;
            r_got     <= 1'b1;
            r_busy    <= 1'b1;
          end else if (r_req_asp || r_req_got) begin
            r_state <= ST_WAIT;
            r_wcnt  <= WAIT_CNT;
          end
        end
        ST_WAIT: begin
          if (w_level_ok) begin
            r_state <= ST_IDLE;
          end else begin
            r_wcnt <= r_wcnt - CNT_W'(1);
          end
        end
        ST_RUN_ASP, ST_RUN_GOT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_adb_use <= 1'b0;
            r_asp     <= 1'b0;
            r_got     <= 1'b0;
            r_adb     <= 1'b0;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= w_cnt_dec;
            r_adb <= r_adb && (w_cnt_dec > ADB_THR);
          end
        end
        ST_FAULT: begin
          r_req_asp   <= 1'b0;
          r_req_got   <= 1'b0;
          r_adb_armed <= 1'b0;
          if (w_any_press) begin
            r_state <= ST_IDLE;
            r_fault <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_to_fault) begin
        r_state     <= ST_FAULT;
        r_cnt       <= '0;
        r_req_asp   <= 1'b0;
        r_req_got   <= 1'b0;
        r_adb_armed <= 1'b0;
        r_adb_use   <= 1'b0;
        r_asp       <= 1'b0;
        r_got       <= 1'b0;
        r_adb       <= 1'b0;
        r_busy      <= 1'b0;
        r_fault     <= 1'b1;
      end
    end
  end

  assign asp       = r_asp;
  assign got       = r_got;
  assign adb       = r_adb;
  assign busy      = r_busy;
  assign fault     = r_fault;
  assign state     = r_state;
  assign remaining = r_cnt;

endmodule

// File: tb/tb_irrig_cmd_sequencer.sv
// Bench for irrig_cmd_sequencer: directed scenarios plus random stimulus
// against a tick-level behavioural model of the sequencer rules.
module tb_irrig_cmd_sequencer;

  localparam int DEB  = 3;
  localparam int ASP  = 20;
  localparam int GOT  = 40;
  localparam int ADB  = 5;
  localparam int MINL = 2;
  localparam int WMAX = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       btn_asp;
  logic       btn_got;
  logic       btn_adb;
  logic [2:0] nivel;
  logic       ve;
  logic       asp;
  logic       got;
  logic       adb;
  logic       busy;
  logic       fault;
  logic [2:0] state;
  logic [7:0] remaining;

  int n_cmp;
  int n_bad;

  // model state: debounced level, stable-run length, FSM
  bit m_deb[3];
  int m_run[3];
  int m_st;
  int m_cnt;
  int m_wcnt;
  bit m_rasp;
  bit m_rgot;
  bit m_arm;
  bit m_use;

  irrig_cmd_sequencer #(
    .DEB_TICKS(DEB), .ASP_TICKS(ASP), .GOT_TICKS(GOT),
    .ADB_TICKS(ADB), .MIN_LEVEL(MINL), .WAIT_MAX(WMAX)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .btn_asp   (btn_asp),
    .btn_got   (btn_got),
    .btn_adb   (btn_adb),
    .nivel     (nivel),
    .ve        (ve),
    .asp       (asp),
    .got       (got),
    .adb       (adb),
    .busy      (busy),
    .fault     (fault),
    .state     (state),
    .remaining (remaining)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired, required summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] dut_vec();
    return {asp, got, adb, busy, fault, state, remaining};
  endfunction

  function automatic logic [15:0] mdl_vec();
    logic [7:0] rem;
    logic       a;
    rem = (m_st == 2 || m_st == 3) ? 8'(m_cnt) : 8'd0;
    a = (m_st == 2) && m_use && ((ASP - m_cnt) < ADB);
    return {m_st == 2, m_st == 3, a, m_st == 2 || m_st == 3,
            m_st == 4, 3'(m_st), rem};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_deb[i] = 1'b0;
      m_run[i] = 0;
    end
    m_st = 0; m_cnt = 0; m_wcnt = 0;
    m_rasp = 0; m_rgot = 0; m_arm = 0; m_use = 0;
  endtask

  task automatic m_step();
    bit pr[3];
    bit raw[3];
    bit lok;
    int prev;
    raw[0] = btn_asp; raw[1] = btn_got; raw[2] = btn_adb;
    for (int i = 0; i < 3; i++) begin
      pr[i] = 1'b0;
      if (raw[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_deb[i] = raw[i];
          m_run[i] = 0;
          pr[i] = raw[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    lok = (int'(nivel) >= MINL) && !ve;
    prev = m_st;
    case (prev)
      0: begin
        if (m_rasp && lok) begin
          m_st = 2; m_cnt = ASP; m_rasp = 0; m_use = m_arm; m_arm = 0;
        end else if (m_rgot && lok) begin
          m_st = 3; m_cnt = GOT; m_rgot = 0;
        end else if (m_rasp || m_rgot) begin
          m_st = 1; m_wcnt = WMAX;
        end
      end
      1: begin
        if (lok) m_st = 0;
        else begin
          m_wcnt--;
          if (m_wcnt == 0) m_st = 4;
        end
      end
      2, 3: begin
        if (nivel == 3'd0) m_st = 4;
        else if (m_cnt == 1) begin
          m_st = 0; m_cnt = 0; m_use = 0;
        end else m_cnt--;
      end
      default: begin
        if (pr[0] || pr[1] || pr[2]) m_st = 0;
      end
    endcase
    if (m_st == 4 && prev != 4) begin
      m_rasp = 0; m_rgot = 0; m_arm = 0; m_use = 0; m_cnt = 0;
    end else if (prev != 4) begin
      m_rasp |= pr[0]; m_rgot |= pr[1]; m_arm |= pr[2];
    end
  endtask

  // One tick every four clocks; inputs settle through the synchronizer first.
  task automatic step();
    repeat (3) @(negedge clock);
    tick = 1'b1;
    @(negedge clock);
    tick = 1'b0;
    m_step();
  endtask

  task automatic test_reset();
    btn_asp = 0; btn_got = 0; btn_adb = 0; nivel = 3'd5; ve = 0;
    @(negedge clock);
    reset = 1'b1; tick = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (dut_vec() !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_state: got %h required 0000", dut_vec());
    end
    reset = 1'b0; tick = 1'b0;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL reset_idle: got %h required %h", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_adb_asp();
    int na;
    int nd;
    int bad_adb;
    nivel = 3'd5; ve = 0; btn_adb = 1;
    for (int i = 0; i < 5; i++) step();
    btn_adb = 0;
    for (int r = 0; r < 2; r++) begin
      btn_asp = 1; na = 0; nd = 0; bad_adb = 0;
      for (int i = 0; i < 30; i++) begin
        if (i == 5) btn_asp = 0;
        step();
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
          n_bad++;
          $display("FAIL adb_run%0d t%0d: got %h required %h",
                   r, i, dut_vec(), mdl_vec());
        end
        na += int'(asp);
        nd += int'(adb);
        if (adb && !asp) bad_adb++;
      end
      n_cmp++;
      if (na != ASP) begin
        n_bad++;
        $display("FAIL asp_len%0d: got %0d required %0d", r, na, ASP);
      end
      n_cmp++;
      if (nd != ((r == 0) ? ADB : 0) || bad_adb != 0) begin
        n_bad++;
        $display("FAIL adb_len%0d: got %0d (orphan %0d) required %0d",
                 r, nd, bad_adb, (r == 0) ? ADB : 0);
      end
    end
  endtask

  task automatic test_simultaneous();
    int na, ng, ov, gap;
    bit sa, sg;
    na = 0; ng = 0; ov = 0; gap = 0; sa = 0; sg = 0;
    nivel = 3'd5; ve = 0; btn_asp = 1; btn_got = 1;
    for (int i = 0; i < 70; i++) begin
      if (i == 5) begin
        btn_asp = 0; btn_got = 0;
      end
      step();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL simul t%0d: got %h required %h", i, dut_vec(), mdl_vec());
      end
      na += int'(asp); ng += int'(got); ov += int'(asp & got);
      if (asp) sa = 1;
      if (got) sg = 1;
      if (sa && !sg && !asp && state == 3'd0) gap++;
    end
    n_cmp++;
    if (na != ASP || ng != GOT || ov != 0 || gap != 1) begin
      n_bad++;
      $display("FAIL simul_seq: asp=%0d got=%0d ovl=%0d gap=%0d required %0d %0d 0 1",
               na, ng, ov, gap, ASP, GOT);
    end
  endtask

  task automatic test_low_water();
    int k;
    for (int p = 0; p < 2; p++) begin
      nivel = 3'd1; ve = 0; btn_got = 1; k = 0;
      while (state !== 3'd1 && k < 20) begin
        step(); k++;
      end
      n_cmp++;
      if (k != DEB + 1) begin
        n_bad++;
        $display("FAIL wait_entry%0d: got %0d ticks state %0d required %0d ticks state 1",
                 p, k, state, DEB + 1);
      end
      btn_got = 0;
      if (p == 0) begin
        for (int i = 0; i < 10; i++) begin
          step();
          n_cmp++;
          if (dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL wait_hold t%0d: got %h required %h", i, dut_vec(), mdl_vec());
          end
        end
        nivel = 3'd3;
        step();
        n_cmp++;
        if (state !== 3'd0) begin
          n_bad++;
          $display("FAIL wait_refill: state %0d required 0", state);
        end
        step();
        n_cmp++;
        if (state !== 3'd3 || got !== 1'b1) begin
          n_bad++;
          $display("FAIL wait_dispatch: state %0d got %b required 3 1", state, got);
        end
        for (int i = 0; i < GOT; i++) begin
          step();
          n_cmp++;
          if (dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL wait_run t%0d: got %h required %h", i, dut_vec(), mdl_vec());
          end
        end
      end else begin
        k = 0;
        while (state !== 3'd4 && k < 150) begin
          step(); k++;
        end
        n_cmp++;
        if (k != WMAX || fault !== 1'b1) begin
          n_bad++;
          $display("FAIL wait_timeout: %0d ticks fault %b required %0d ticks fault 1",
                   k, fault, WMAX);
        end
        btn_asp = 1;
        for (int i = 0; i < 10; i++) begin
          if (i == 5) btn_asp = 0;
          step();
          n_cmp++;
          if (dut_vec() !== mdl_vec()) begin
            n_bad++;
            $display("FAIL fault_exit t%0d: got %h required %h", i, dut_vec(), mdl_vec());
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    int k;
    nivel = 3'd5; ve = 0; btn_got = 1; k = 0;
    while (state !== 3'd3 && k < 20) begin
      step(); k++;
    end
    n_cmp++;
    if (k != DEB + 1) begin
      n_bad++;
      $display("FAIL abort_start: %0d ticks state %0d required %0d ticks state 3",
               k, state, DEB + 1);
    end
    btn_got = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) btn_got = 1;
      step();
    end
    nivel = 3'd0;
    step();
    n_cmp++;
    if (dut_vec() !== 16'h0C00) begin
      n_bad++;
      $display("FAIL abort_fault: got %h required 0c00", dut_vec());
    end
    nivel = 3'd5; btn_got = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) btn_adb = 1;
      if (i == 9) btn_adb = 0;
      step();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL abort_after t%0d: got %h required %h", i, dut_vec(), mdl_vec());
      end
    end
    n_cmp++;
    if (state !== 3'd0) begin
      n_bad++;
      $display("FAIL abort_cleared: state %0d required 0", state);
    end
  endtask

  task automatic test_glitch();
    int nr, na;
    logic pa;
    nivel = 3'd5; ve = 0; btn_asp = 1;
    step(); step();
    btn_asp = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (state !== 3'd0) begin
        n_bad++;
        $display("FAIL glitch t%0d: state %0d required 0", i, state);
      end
    end
    btn_asp = 1; nr = 0; na = 0; pa = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL hold t%0d: got %h required %h", i, dut_vec(), mdl_vec());
      end
      if (asp && !pa) nr++;
      pa = asp;
      na += int'(asp);
    end
    n_cmp++;
    if (nr != 1 || na != ASP) begin
      n_bad++;
      $display("FAIL hold_once: runs %0d ticks %0d required 1 %0d", nr, na, ASP);
    end
    btn_asp = 0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid_run();
    int k;
    nivel = 3'd5; ve = 0; btn_asp = 1; k = 0;
    while (remaining !== 8'd7 && k < 40) begin
      if (k == 5) btn_asp = 0;
      step(); k++;
    end
    btn_asp = 0;
    n_cmp++;
    if (remaining !== 8'd7 || state !== 3'd2) begin
      n_bad++;
      $display("FAIL mid_run_reach: rem %0d state %0d required 7 2", remaining, state);
    end
    reset = 1'b1; tick = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (dut_vec() !== 16'h0000) begin
      n_bad++;
      $display("FAIL mid_run_reset: got %h required 0000", dut_vec());
    end
    reset = 1'b0; tick = 1'b0;
    m_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (state !== 3'd0 || dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL no_resume t%0d: got %h required %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) btn_asp = ~btn_asp;
      if ($urandom_range(7) == 0) btn_got = ~btn_got;
      if ($urandom_range(7) == 0) btn_adb = ~btn_adb;
      if ($urandom_range(9) == 0)
        nivel = ($urandom_range(19) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
      if ($urandom_range(15) == 0) ve = ~ve;
      step();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL random t%0d: got %h required %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 0; tick = 0;
    btn_asp = 0; btn_got = 0; btn_adb = 0;
    nivel = 3'd5; ve = 0;
    m_reset();
    test_reset();
    test_adb_asp();
    test_simultaneous();
    test_low_water();
    test_abort();
    test_glitch();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
